// File: rtl/button_toggle_led_pkg.sv
// Shared constants and helpers for the push-button / LED block.
package button_toggle_led_pkg;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

   // Counter must be able to hold 0..cycles, hence the +1.
   function automatic int counterWidth(input int cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes a raw button level, debounces it and emits a one-cycle
// pulse on every accepted 0->1 transition.
module button_debouncer
   import button_toggle_led_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic button,
   output logic pressed
);

   localparam int CW = counterWidth(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          deb_q;
   logic          deb_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          pressed_q;
   logic          pressed_d;

   // Any sample that agrees with the accepted level restarts the qualification window.
   always_comb begin
      deb_d     = deb_q;
      cnt_d     = cnt_q;
      pressed_d = 1'b0;
      if (sync2_q == deb_q) begin
         cnt_d = '0;
      end else if (cnt_q == LAST_COUNT) begin
         deb_d     = sync2_q;
         cnt_d     = '0;
         pressed_d = sync2_q;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         deb_q     <= 1'b0;
         cnt_q     <= '0;
         pressed_q <= 1'b0;
      end else begin
         sync1_q   <= button;
         sync2_q   <= sync1_q;
         deb_q     <= deb_d;
         cnt_q     <= cnt_d;
         pressed_q <= pressed_d;
      end
   end

   assign pressed = pressed_q;

endmodule

// File: rtl/button_toggle_led.sv
// Top-level user-input block: button pin in, toggling LED out, press pulse exported.
module button_toggle_led
   import button_toggle_led_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
   parameter bit BUTTON_ACTIVE_LOW = 1'b0,
   parameter bit LED_RESET_VALUE   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic button,
   output logic pressed,
   output logic led
);

   logic buttonCond;
   logic pressPulse;
   logic led_q;
   logic led_d;

   // Normalise polarity so the debouncer always sees pressed = 1.
   assign buttonCond = button ^ BUTTON_ACTIVE_LOW;

   button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debouncer (
      .clk    (clk),
      .rst    (rst),
      .button (buttonCond),
      .pressed(pressPulse)
   );

   assign led_d = led_q ^ pressPulse;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led_q <= LED_RESET_VALUE;
      end else begin
         led_q <= led_d;
      end
   end

   assign pressed = pressPulse;
   assign led     = led_q;

endmodule

// File: tb/tb_button_toggle_led.sv
// Bench for button_toggle_led: a default instance plus a swept-parameter instance,
// each checked every cycle against a sample-history model of the debounce rules.
module tb_button_toggle_led;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic button1 = 1'b0;
   logic button2 = 1'b1;
   logic pressed1, led1, pressed2, led2;

   int compared = 0;
   int mismatched = 0;
   bit chkOn = 1'b0;

   button_toggle_led dut1 (
      .clk(clk), .rst(rst), .button(button1), .pressed(pressed1), .led(led1)
   );

   button_toggle_led #(
      .DEBOUNCE_CYCLES(1), .BUTTON_ACTIVE_LOW(1'b1), .LED_RESET_VALUE(1'b1)
   ) dut2 (
      .clk(clk), .rst(rst), .button(button2), .pressed(pressed2), .led(led2)
   );

   initial begin
      #20;
      forever #5 clk = ~clk;
   end

   // Level is accepted once the N synchronized samples (b delayed two edges) all disagree with it.
   function automatic bit stableFor(input logic [15:0] h, input int n, input bit v);
      for (int i = 1; i <= n; i++)
         if (h[i] != v) return 1'b0;
      return 1'b1;
   endfunction

   logic [15:0] hist1, hist2;
   bit debM1, pressedM1, ledM1;
   bit debM2, pressedM2, ledM2;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         hist1 <= '0; debM1 <= 1'b0; pressedM1 <= 1'b0; ledM1 <= 1'b0;
      end else begin
         ledM1 <= ledM1 ^ pressedM1;
         if (stableFor(hist1, 4, !debM1)) begin
            debM1 <= !debM1;
            pressedM1 <= !debM1;
         end else begin
            pressedM1 <= 1'b0;
         end
         hist1 <= {hist1[14:0], button1};
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         hist2 <= '0; debM2 <= 1'b0; pressedM2 <= 1'b0; ledM2 <= 1'b1;
      end else begin
         ledM2 <= ledM2 ^ pressedM2;
         if (stableFor(hist2, 1, !debM2)) begin
            debM2 <= !debM2;
            pressedM2 <= !debM2;
         end else begin
            pressedM2 <= 1'b0;
         end
         hist2 <= {hist2[14:0], ~button2};
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chkOn && !rst) begin
         checkOutput("model pressed1", int'(pressed1), int'(pressedM1));
         checkOutput("model led1", int'(led1), int'(ledM1));
         checkOutput("model pressed2", int'(pressed2), int'(pressedM2));
         checkOutput("model led2", int'(led2), int'(ledM2));
      end
   end

   task automatic applyStimulus(input bit b1, input bit b2, input int cycles);
      button1 = b1;
      button2 = b2;
      repeat (cycles) @(negedge clk);
   endtask

   // Edges counted from the drive point; -1 when the budget expires.
   task automatic measurePulse(input bit which, input int budget, output int at);
      at = -1;
      for (int i = 1; i <= budget; i++) begin
         @(posedge clk);
         @(negedge clk);
         if ((which ? pressed2 : pressed1) == 1'b1) begin
            at = i;
            break;
         end
      end
   endtask

   task automatic countPulses(input bit which, input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if ((which ? pressed2 : pressed1) == 1'b1) n++;
      end
   endtask

   initial begin
      int at, n, total, run1, run2;
      bit expLed;

      #1 rst = 1'b1;
      #1;
      checkOutput("reset pressed1", int'(pressed1), 0);
      checkOutput("reset led1", int'(led1), 0);
      checkOutput("reset pressed2", int'(pressed2), 0);
      checkOutput("reset led2", int'(led2), 1);
      button1 = 1'b1;

      @(negedge clk);
      chkOn = 1'b1;
      rst = 1'b0;
      measurePulse(1'b0, 20, at);
      checkOutput("held-through-reset pulse edge", at, 6);
      countPulses(1'b0, 44, n);
      checkOutput("long hold extra pulses", n, 0);
      checkOutput("long hold led1", int'(led1), 1);
      button1 = 1'b0;
      countPulses(1'b0, 20, n);
      checkOutput("release pulses", n, 0);
      checkOutput("release led1", int'(led1), 1);

      total = 0;
      for (int r = 0; r < 10; r++) begin
         button1 = 1'b1;
         countPulses(1'b0, 3, n);
         total += n;
         button1 = 1'b0;
         countPulses(1'b0, 3, n);
         total += n;
      end
      countPulses(1'b0, 10, n);
      total += n;
      checkOutput("bounce pulses", total, 0);
      checkOutput("bounce led1", int'(led1), 1);

      expLed = 1'b1;
      for (int p = 0; p < 4; p++) begin
         button1 = 1'b1;
         measurePulse(1'b0, 10, at);
         checkOutput("square pulse edge", at, 6);
         countPulses(1'b0, 1, n);
         checkOutput("square pulse width", n, 0);
         expLed = !expLed;
         checkOutput("square led1", int'(led1), int'(expLed));
         applyStimulus(1'b0, 1'b1, 13);
      end

      button2 = 1'b0;
      measurePulse(1'b1, 10, at);
      checkOutput("N=1 active-low pulse edge", at, 3);
      countPulses(1'b1, 7, n);
      checkOutput("N=1 held extra pulses", n, 0);
      applyStimulus(1'b0, 1'b1, 10);
      checkOutput("N=1 led2 after press", int'(led2), 0);

      button1 = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("mid-debounce reset pressed1", int'(pressed1), 0);
      checkOutput("mid-debounce reset led1", int'(led1), 0);
      checkOutput("mid-debounce reset led2", int'(led2), 1);
      #1 rst = 1'b0;
      measurePulse(1'b0, 20, at);
      checkOutput("requalify pulse edge", at, 6);
      countPulses(1'b0, 3, n);
      checkOutput("requalify led1", int'(led1), 1);
      applyStimulus(1'b0, 1'b1, 10);

      run1 = 0;
      run2 = 0;
      for (int c = 0; c < 1500; c++) begin
         if (run1 == 0) begin
            button1 = 1'($urandom_range(0, 1));
            run1 = $urandom_range(1, 10);
         end
         if (run2 == 0) begin
            button2 = 1'($urandom_range(0, 1));
            run2 = $urandom_range(1, 4);
         end
         run1--;
         run2--;
         @(negedge clk);
      end

      chkOn = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
